// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result drain.
//   drain_state_t     : frame sequencer states
//   HDR_DEFAULT       : default frame header byte
//   SIZE_DEFAULT      : default systolic array dimension
//   ACC_WIDTH_DEFAULT : default accumulator width in bits
//   frame_bytes()     : header + payload + checksum byte count for a given geometry
//   FRAME_BYTES       : frame length at the default geometry (66)
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } drain_state_t;

    localparam logic [7:0] HDR_DEFAULT       = 8'hA5;
    localparam int         SIZE_DEFAULT      = 4;
    localparam int         ACC_WIDTH_DEFAULT = 32;

    function automatic int frame_bytes(input int size, input int acc_width);
        return size * size * acc_width / 8 + 2;
    endfunction

    localparam int FRAME_BYTES = frame_bytes(SIZE_DEFAULT, ACC_WIDTH_DEFAULT);

endpackage

// File: rtl/tpu_result_drain.sv
// Drains a snapshot of the systolic array accumulators as a byte frame:
//   header byte, payload bytes (row-major elements, LSB byte first),
//   then an XOR checksum of the payload bytes.
//
// Ports
//   clk           : rising-edge clock
//   rst           : asynchronous active-high reset
//   done          : compute-complete level; its rising edge starts a frame
//   acc_flat      : accumulator outputs, element (r,c) at [(r*SIZE+c)*ACC_WIDTH +: ACC_WIDTH]
//   tx_data       : outgoing byte
//   tx_valid      : tx_data is valid
//   tx_ready      : sink accepts the byte
//   busy          : a frame is in progress
//   frame_done    : one-cycle pulse coincident with the checksum byte transfer
//   overrun       : sticky, a done edge arrived while a frame was in progress
//   clear_overrun : clears overrun (a simultaneous new overrun wins)
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a done rising edge; no byte offered
// ST_HEADER  | offering the header byte
// ST_PAYLOAD | offering snapshot byte byte_idx, accumulating checksum
// ST_CSUM    | offering the payload checksum; transfer ends the frame
module tpu_result_drain
    import tpu_pkg::*;
#(
    parameter int         SIZE      = SIZE_DEFAULT,
    parameter int         ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter logic [7:0] HDR       = HDR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done,
    input  logic [SIZE*SIZE*ACC_WIDTH-1:0] acc_flat,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    input  logic                          clear_overrun
);

    localparam int PAYLOAD_BYTES = frame_bytes(SIZE, ACC_WIDTH) - 2;
    localparam int IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    drain_state_t state;
    drain_state_t state_nxt;

    logic                          done_q;
    logic                          done_armed;
    logic                          capture;
    logic                          xfer;
    logic [PAYLOAD_BYTES-1:0][7:0] snapshot;
    logic [IDX_W-1:0]              byte_idx;
    logic [7:0]                    csum;

    // done_armed stays low after reset until done is seen low, so a done level
    // that is still high when reset releases does not count as a fresh edge.
    assign capture = done & ~done_q & done_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        frame_done = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                xfer     = tx_ready;
                if (tx_ready) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = snapshot[byte_idx];
                xfer     = tx_ready;
                if (tx_ready && (byte_idx == LAST_IDX)) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                xfer     = tx_ready;
                if (tx_ready) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            done_armed <= 1'b0;
            snapshot   <= '0;
            byte_idx   <= '0;
            csum       <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            done_q     <= done;
            done_armed <= done_armed | ~done;

            if ((state == ST_IDLE) && capture) begin
                snapshot <= acc_flat;
                csum     <= 8'h00;
                byte_idx <= '0;
            end else if ((state == ST_HEADER) && xfer) begin
                byte_idx <= '0;
            end else if ((state == ST_PAYLOAD) && xfer) begin
                csum <= csum ^ tx_data;
                // Hold at the last index rather than wrapping; CSUM follows.
                if (byte_idx != LAST_IDX) begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end

            // Any edge outside IDLE (including the CSUM transfer cycle) is dropped.
            if (capture && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
